disp_vramrd: RTL

// - AXI4 read master that fetches one frame from VRAM and fills the display FIFO, one burst at a time.
// - Sits upstream of the display-output stage. Its frame trigger is that stage's AXISTART, driven one line

---
 rtl/disp_vramrd_if.sv | 22 ++
 rtl/disp_vramrd.sv | 127 ++++++++++++
 2 files changed

// File: rtl/disp_vramrd_if.sv
`timescale 1ns/1ps
// AXI4 read-address and read-data channels between the VRAM frame reader and the interconnect.
interface disp_vramrd_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RDATA, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RDATA, RLAST, RVALID
    );
endinterface

// File: rtl/disp_vramrd.sv
`timescale 1ns/1ps
// VRAM frame reader: on a synchronized frame trigger, fetches one frame as single-outstanding
// AXI4 read bursts and writes every returned beat into the display FIFO.
//
// state  | meaning
// S_IDLE | no frame in progress, waiting for a trigger
// S_WAIT | waiting for FIFO room for one full burst
// S_ADDR | read address presented, waiting for ARREADY
// S_DATA | accepting read beats until RLAST
module disp_vramrd #(
    parameter int H_PIXELS  = 640,
    parameter int V_LINES   = 480,
    parameter int BURST_LEN = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        DISPON,
    input  logic [31:0] DISPADDR,
    input  logic        AXISTART,
    input  logic        FIFO_AFULL,
    output logic        FIFOWR,
    output logic [63:0] FIFOWDATA,
    disp_vramrd_if.master axi,
    output logic        BUSY,
    output logic        STARTERR
);

    localparam int NBURST  = H_PIXELS * V_LINES / (2 * BURST_LEN);
    localparam int BCNT_W  = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int ALIGN_W = $clog2(BURST_LEN * 8);

    localparam logic [31:0]       ADDR_MASK   = ~((32'd1 << ALIGN_W) - 32'd1);
    localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * 8);
    localparam logic [BCNT_W-1:0] LAST_BURST  = BCNT_W'(NBURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_t;

    state_t              r_state;
    logic [1:0]          r_sync;
    logic                r_sync_d;
    logic                r_start;
    logic [31:0]         r_addr;
    logic [BCNT_W-1:0]   r_bcnt;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_fifowr;
    logic [63:0]         r_fifowdata;
    logic                r_starterr;
    logic                w_start_edge;

    assign w_start_edge = r_sync[1] & ~r_sync_d;

    // AXISTART is a PCK-domain level; the registered edge pulse lands 3 ACLK cycles after it rises.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_sync   <= 2'b00;
            r_sync_d <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], AXISTART};
            r_sync_d <= r_sync[1];
            r_start  <= w_start_edge;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_bcnt      <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_fifowr    <= 1'b0;
            r_fifowdata <= 64'd0;
            r_starterr  <= 1'b0;
        end else begin
            r_fifowr   <= 1'b0;
            r_starterr <= r_start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (r_start && DISPON) begin
                        r_state <= S_WAIT;
                        r_addr  <= DISPADDR & ADDR_MASK;
                        r_bcnt  <= '0;
                    end
                end
                S_WAIT: begin
                    if (!FIFO_AFULL) begin
                        r_state   <= S_ADDR;
                        r_arvalid <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (axi.ARREADY) begin
                        r_state   <= S_DATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (axi.RVALID && r_rready) begin
                        r_fifowr    <= 1'b1;
                        r_fifowdata <= axi.RDATA;
                        if (axi.RLAST) begin
                            // Wraps modulo 2^32 by design; alignment keeps bursts inside 4 KB pages.
                            r_addr   <= r_addr + BURST_BYTES;
                            r_bcnt   <= r_bcnt + BCNT_W'(1);
                            r_rready <= 1'b0;
                            r_state  <= (r_bcnt == LAST_BURST) ? S_IDLE : S_WAIT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign axi.ARADDR  = r_addr;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARVALID = r_arvalid;
    assign axi.RREADY  = r_rready;
    assign FIFOWR      = r_fifowr;
    assign FIFOWDATA   = r_fifowdata;
    assign STARTERR    = r_starterr;
    assign BUSY        = (r_state != S_IDLE);

endmodule
